// File: rtl/led_readback.sv
// LED activity readback: synchronizes the LED drive vector, counts rising edges per LED
// over a fixed window and latches a per-LED classification plus counts into shadow registers.
module led_readback #(
   parameter int WINDOW_CYCLES = 40079000,
   parameter int COUNT_WIDTH   = 8,
   parameter int N_LEDS        = 16,
   parameter int SYNC_STAGES   = 2
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     enable_i,
   input  logic [N_LEDS-1:0]        led_i,
   input  logic [3:0]               rd_sel_i,
   output logic [COUNT_WIDTH-1:0]   rd_count_o,
   output logic [2*N_LEDS-1:0]      led_state_o,
   output logic                     window_valid_o,
   output logic [15:0]              windows_done_o
);

   localparam int WW = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
   localparam int FW = $clog2(SYNC_STAGES + 2);
   localparam logic [WW-1:0]          WIN_LAST   = WW'(WINDOW_CYCLES - 1);
   localparam logic [FW-1:0]          FLUSH_LAST = FW'(SYNC_STAGES);
   localparam logic [COUNT_WIDTH-1:0] CNT_MAX    = {COUNT_WIDTH{1'b1}};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FLUSH = 2'd1,
      ST_RUN   = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [FW-1:0]           flush_cnt_q, flush_cnt_d;
   logic [WW-1:0]           win_cnt_q, win_cnt_d;
   logic [N_LEDS-1:0]       sync_q [SYNC_STAGES];
   logic [N_LEDS-1:0]       prev_q;
   logic [COUNT_WIDTH-1:0]  live_cnt_q [N_LEDS];
   logic [COUNT_WIDTH-1:0]  live_cnt_d [N_LEDS];
   logic [COUNT_WIDTH-1:0]  shadow_cnt_q [N_LEDS];
   logic [COUNT_WIDTH-1:0]  shadow_cnt_d [N_LEDS];
   logic [N_LEDS-1:0]       seen_q, seen_d;
   logic [2*N_LEDS-1:0]     led_state_q, led_state_d;
   logic                    valid_q, valid_d;
   logic [15:0]             done_q, done_d;
   logic [COUNT_WIDTH-1:0]  rd_count_q, rd_count_d;

   logic [N_LEDS-1:0]       synced;
   logic [N_LEDS-1:0]       rise;
   logic [N_LEDS-1:0]       seen_fin;
   logic [COUNT_WIDTH-1:0]  edges_fin [N_LEDS];
   logic                    terminal;

   function automatic logic [1:0] classify(input logic [COUNT_WIDTH-1:0] edges, input logic seen);
      logic [1:0] cls;
      if (edges == CNT_MAX) begin
         cls = 2'b11;
      end else if (edges != {COUNT_WIDTH{1'b0}}) begin
         cls = 2'b10;
      end else if (seen) begin
         cls = 2'b01;
      end else begin
         cls = 2'b00;
      end
      return cls;
   endfunction

   // Synchronizer chain and previous-sample register; runs in every state
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
         prev_q <= '0;
      end else begin
         sync_q[0] <= led_i;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign synced = sync_q[SYNC_STAGES-1];
   assign rise   = synced & ~prev_q;

   // Window results including the current cycle, so a terminal-cycle edge lands in the ending window
   always_comb begin
      terminal = (state_q == ST_RUN) && (win_cnt_q == WIN_LAST);
      seen_fin = seen_q | synced;
      for (int k = 0; k < N_LEDS; k++) begin
         if (rise[k] && (live_cnt_q[k] != CNT_MAX)) begin
            edges_fin[k] = live_cnt_q[k] + COUNT_WIDTH'(1);
         end else begin
            edges_fin[k] = live_cnt_q[k];
         end
      end
   end

   // Next-state logic: FSM, live counters, shadow latch and readback mux
   always_comb begin
      state_d     = state_q;
      flush_cnt_d = flush_cnt_q;
      win_cnt_d   = win_cnt_q;
      seen_d      = seen_q;
      led_state_d = led_state_q;
      valid_d     = 1'b0;
      done_d      = done_q;
      rd_count_d  = '0;
      for (int k = 0; k < N_LEDS; k++) begin
         live_cnt_d[k]   = live_cnt_q[k];
         shadow_cnt_d[k] = shadow_cnt_q[k];
      end

      case (state_q)
         ST_IDLE: begin
            flush_cnt_d = '0;
            win_cnt_d   = '0;
            seen_d      = '0;
            for (int k = 0; k < N_LEDS; k++) live_cnt_d[k] = '0;
            if (enable_i) begin
               state_d = ST_FLUSH;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_FLUSH: begin
            win_cnt_d = '0;
            seen_d    = '0;
            for (int k = 0; k < N_LEDS; k++) live_cnt_d[k] = '0;
            if (!enable_i) begin
               state_d = ST_IDLE;
            end else if (flush_cnt_q == FLUSH_LAST) begin
               state_d = ST_RUN;
            end else begin
               flush_cnt_d = flush_cnt_q + FW'(1);
            end
         end
         ST_RUN: begin
            if (terminal) begin
               for (int k = 0; k < N_LEDS; k++) begin
                  shadow_cnt_d[k]        = edges_fin[k];
                  led_state_d[2*k +: 2]  = classify(edges_fin[k], seen_fin[k]);
                  live_cnt_d[k]          = '0;
               end
               seen_d    = '0;
               win_cnt_d = '0;
               valid_d   = 1'b1;
               done_d    = done_q + 16'd1;
               if (enable_i) begin
                  state_d = ST_RUN;
               end else begin
                  state_d = ST_IDLE;
               end
            end else if (!enable_i) begin
               state_d = ST_IDLE;
            end else begin
               win_cnt_d = win_cnt_q + WW'(1);
               seen_d    = seen_fin;
               for (int k = 0; k < N_LEDS; k++) live_cnt_d[k] = edges_fin[k];
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Forward the value being latched so the readback is current in the valid cycle
      if (int'(rd_sel_i) < N_LEDS) begin
         if (terminal) begin
            rd_count_d = edges_fin[rd_sel_i];
         end else begin
            rd_count_d = shadow_cnt_q[rd_sel_i];
         end
      end else begin
         rd_count_d = '0;
      end
   end

   // State and result registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         flush_cnt_q <= '0;
         win_cnt_q   <= '0;
         seen_q      <= '0;
         led_state_q <= '0;
         valid_q     <= 1'b0;
         done_q      <= 16'd0;
         rd_count_q  <= '0;
         for (int k = 0; k < N_LEDS; k++) begin
            live_cnt_q[k]   <= '0;
            shadow_cnt_q[k] <= '0;
         end
      end else begin
         state_q     <= state_d;
         flush_cnt_q <= flush_cnt_d;
         win_cnt_q   <= win_cnt_d;
         seen_q      <= seen_d;
         led_state_q <= led_state_d;
         valid_q     <= valid_d;
         done_q      <= done_d;
         rd_count_q  <= rd_count_d;
         for (int k = 0; k < N_LEDS; k++) begin
            live_cnt_q[k]   <= live_cnt_d[k];
            shadow_cnt_q[k] <= shadow_cnt_d[k];
         end
      end
   end

   assign rd_count_o     = rd_count_q;
   assign led_state_o    = led_state_q;
   assign window_valid_o = valid_q;
   assign windows_done_o = done_q;

endmodule

// File: tb/tb_led_readback.sv
// Directed self-checking bench for led_readback: one instance with a 100-cycle window
// and a second with a 600-cycle window for the saturation case.
module tb_led_readback;

   logic        clock;
   logic        reset_n;
   logic        enable_i;
   logic [15:0] led_v;
   logic [3:0]  rd_sel;
   logic [3:0]  rd_sel2;

   logic [7:0]  rd_count0, rd_count2;
   logic [31:0] led_state0, led_state2;
   logic        valid0, valid2;
   logic [15:0] done0, done2;

   int n_checks;
   int n_errors;
   int cyc;
   int pulses0;
   bit blink_en;
   bit fast_en;

   led_readback #(.WINDOW_CYCLES(100), .COUNT_WIDTH(8), .N_LEDS(16), .SYNC_STAGES(2)) dut0 (
      .clock          (clock),
      .reset_n        (reset_n),
      .enable_i       (enable_i),
      .led_i          (led_v),
      .rd_sel_i       (rd_sel),
      .rd_count_o     (rd_count0),
      .led_state_o    (led_state0),
      .window_valid_o (valid0),
      .windows_done_o (done0)
   );

   led_readback #(.WINDOW_CYCLES(600), .COUNT_WIDTH(8), .N_LEDS(16), .SYNC_STAGES(2)) dut2 (
      .clock          (clock),
      .reset_n        (reset_n),
      .enable_i       (enable_i),
      .led_i          (led_v),
      .rd_sel_i       (rd_sel2),
      .rd_count_o     (rd_count2),
      .led_state_o    (led_state2),
      .window_valid_o (valid2),
      .windows_done_o (done2)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One clock: sample just after the edge, then apply pattern generators
   task automatic tick();
      @(posedge clock);
      #1;
      cyc++;
      if (valid0) pulses0++;
      if (blink_en && (cyc % 5 == 0)) led_v[0] = ~led_v[0];
      if (fast_en) led_v[15] = ~led_v[15];
   endtask

   task automatic wait_pulse(input string tag, input bit which, input int max, output int n);
      bit got;
      got = 1'b0;
      n   = 0;
      while (!got && n < max) begin
         tick();
         n++;
         got = which ? valid2 : valid0;
      end
      check_value(tag, 32'(got), 32'd1);
   endtask

   initial begin
      int n;
      int snap;
      int p_before;
      n_checks = 0;
      n_errors = 0;
      cyc      = 0;
      pulses0  = 0;
      blink_en = 1'b0;
      fast_en  = 1'b0;
      reset_n  = 1'b0;
      enable_i = 1'b0;
      led_v    = 16'hFFFF;
      rd_sel   = 4'd0;
      rd_sel2  = 4'd15;

      // Reset with toggling LEDs
      for (int i = 0; i < 10; i++) begin
         tick();
         led_v = ~led_v;
      end
      check_value("rst_rd_count", 32'(rd_count0), 32'd0);
      check_value("rst_led_state", led_state0, 32'd0);
      check_value("rst_valid", 32'(valid0), 32'd0);
      check_value("rst_done", 32'(done0), 32'd0);

      reset_n = 1'b1;
      led_v   = 16'h0000;
      pulses0 = 0;
      for (int i = 0; i < 500; i++) tick();
      check_value("idle_pulses", 32'(pulses0), 32'd0);
      check_value("idle_led_state", led_state0, 32'd0);
      check_value("idle_done", 32'(done0), 32'd0);
      check_value("idle_rd_count", 32'(rd_count0), 32'd0);

      // Static levels
      led_v = 16'h00F0;
      rd_sel = 4'd4;
      for (int i = 0; i < 5; i++) tick();
      enable_i = 1'b1;
      wait_pulse("static_pulse", 1'b0, 300, n);
      check_value("static_latency", 32'(n), 32'd104);
      check_value("static_led_state", led_state0, 32'h0000_5500);
      check_value("static_rd_count", 32'(rd_count0), 32'd0);
      check_value("static_done", 32'(done0), 32'd1);

      // Blink counting on LED 0
      rd_sel   = 4'd0;
      blink_en = 1'b1;
      wait_pulse("blink_skip", 1'b0, 200, n);
      for (int i = 0; i < 3; i++) begin
         wait_pulse("blink_pulse", 1'b0, 200, n);
         check_value("blink_gap", 32'(n), 32'd100);
         check_value("blink_count", 32'(rd_count0), 32'd10);
         check_value("blink_led_state", led_state0, 32'h0000_5502);
         check_value("blink_done", 32'(done0), 32'(3 + i));
      end

      // Fast toggle on LED 15: 50 rises in a 100 window, 300 (saturated) in a 600 window
      rd_sel  = 4'd15;
      fast_en = 1'b1;
      wait_pulse("fast_skip", 1'b0, 200, n);
      wait_pulse("fast_pulse", 1'b0, 200, n);
      check_value("fast_count_w100", 32'(rd_count0), 32'd50);
      check_value("fast_led_state_w100", led_state0, 32'h8000_5502);
      wait_pulse("sat_skip", 1'b1, 1300, n);
      wait_pulse("sat_pulse", 1'b1, 1300, n);
      check_value("sat_count", 32'(rd_count2), 32'd255);
      check_value("sat_led_state", led_state2, 32'hC000_5502);

      // Single edge on LED 3 sampled in the terminal cycle
      blink_en = 1'b0;
      fast_en  = 1'b0;
      led_v    = 16'h00F0;
      rd_sel   = 4'd3;
      wait_pulse("term_settle_a", 1'b0, 200, n);
      wait_pulse("term_settle_b", 1'b0, 200, n);
      for (int i = 0; i < 97; i++) tick();
      led_v[3] = 1'b1;
      wait_pulse("term_pulse", 1'b0, 200, n);
      check_value("term_latency", 32'(n), 32'd3);
      check_value("term_count", 32'(rd_count0), 32'd1);
      check_value("term_led_state", led_state0, 32'h0000_5580);
      wait_pulse("term_next_pulse", 1'b0, 200, n);
      check_value("term_next_gap", 32'(n), 32'd100);
      check_value("term_next_count", 32'(rd_count0), 32'd0);
      check_value("term_next_led_state", led_state0, 32'h0000_5540);

      // Abort mid-window
      for (int i = 0; i < 50; i++) tick();
      enable_i = 1'b0;
      snap     = int'(done0);
      p_before = pulses0;
      for (int i = 0; i < 300; i++) tick();
      check_value("abort_pulses", 32'(pulses0), 32'(p_before));
      check_value("abort_done", 32'(done0), 32'(snap));
      check_value("abort_led_state", led_state0, 32'h0000_5540);
      check_value("abort_rd_count", 32'(rd_count0), 32'd0);

      enable_i = 1'b1;
      wait_pulse("rerun_pulse", 1'b0, 300, n);
      check_value("rerun_latency", 32'(n), 32'd104);
      check_value("rerun_done", 32'(done0), 32'(snap + 1));
      check_value("rerun_led_state", led_state0, 32'h0000_5540);

      // Enable dropped in the terminal cycle still completes the window
      for (int i = 0; i < 99; i++) tick();
      enable_i = 1'b0;
      tick();
      check_value("termdrop_valid", 32'(valid0), 32'd1);
      check_value("termdrop_done", 32'(done0), 32'(snap + 2));
      p_before = pulses0;
      for (int i = 0; i < 250; i++) tick();
      check_value("termdrop_idle_pulses", 32'(pulses0), 32'(p_before));
      check_value("termdrop_idle_done", 32'(done0), 32'(snap + 2));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/led_readback.md
Name: led_readback

Overview:
- Monitors the 16-bit front-panel LED drive vector and decodes it back into per-LED activity data for slow-control readback.
- Over a fixed measurement window it counts rising edges per LED and classifies each LED as OFF, ON, BLINK or SATURATED.
- Results are latched into shadow registers so software can verify LED behaviour, such as TTC flashers and the rate bar, without looking at the board.
- Sits beside the LED driver and taps its output vector; results go to the register file.

Parameters:
- WINDOW_CYCLES, 40079000, measurement window length in clock cycles (1 s at the LHC clock); must be >= 2.
- COUNT_WIDTH, 8, width of each per-LED saturating edge counter.
- N_LEDS, 16, number of monitored LEDs.
- SYNC_STAGES, 2, synchronizer depth on led_i; must be >= 2.

Ports:
- clock  in  1  system clock (40 MHz LHC).
- reset_n  in  1  asynchronous, active-low reset.
- enable_i  in  1  level; measurement runs while high.
- led_i  in  N_LEDS  LED drive vector; bits may be asynchronous (some LEDs are driven from the config oscillator).
- rd_sel_i  in  4  LED index for count readback.
- rd_count_o  out  COUNT_WIDTH  latched edge count of LED rd_sel_i.
- led_state_o  out  2*N_LEDS  latched class per LED; LED k occupies bits [2k+1:2k].
- window_valid_o  out  1  one-cycle pulse when new results are latched.
- windows_done_o  out  16  count of completed windows; wraps at 0xFFFF->0.

Behaviour:
- Reset (async assert, release synchronous to clock):
  - All outputs 0.
  - FSM goes to IDLE.
  - Live counters, flags, shadows and synchronizers cleared.
- Input path: each led_i bit passes through a SYNC_STAGES flop chain, then a one-flop previous-sample register. A rising edge is synced=1 while prev=0. The synchronizer runs in every state.
- FSM states:
  - IDLE: counters held at 0. enable_i=1 -> FLUSH.
  - FLUSH: waits SYNC_STAGES+1 cycles so stale samples drain, then -> RUN with the window counter at 0. enable_i=0 during FLUSH -> IDLE.
  - RUN:
    - Window counter increments 0..WINDOW_CYCLES-1.
    - Each cycle, each LED's live edge counter increments on a rising edge and saturates at 2^COUNT_WIDTH-1.
    - Each LED's seen_high flag is set whenever its synced sample is 1.
  - RUN terminal cycle (window counter = WINDOW_CYCLES-1):
    - An edge or high sample in this cycle is included in the ending window.
    - At the closing clock edge: shadows load the classified results, live counters and flags clear, the window counter returns to 0, and windows_done_o increments.
    - window_valid_o is 1 for exactly the next cycle.
    - The next window starts with no dead cycle.
  - enable_i=0 in RUN: abort to IDLE the next cycle. The partial window is discarded, shadows and windows_done_o are unchanged, and no valid pulse is generated.
  - enable_i=0 in the terminal cycle itself: the window completes and latches as normal, then the FSM goes to IDLE.
- Classification per LED (edges = live count, max = 2^COUNT_WIDTH-1):
  - edges=0 and seen_high=0 -> 2'b00 OFF.
  - edges=0 and seen_high=1 -> 2'b01 ON (includes high-then-fall-once).
  - 1 <= edges < max -> 2'b10 BLINK.
  - edges=max -> 2'b11 SATURATED.
- Readback: rd_count_o is registered, with a 1-cycle latency from rd_sel_i. It reads the shadow count for that LED.
- Shadow update and rd_sel_i change in the same cycle: rd_count_o reflects the newly latched shadow value on the following cycle.
- Shadows hold their values indefinitely in IDLE.

Test Plan (bench uses WINDOW_CYCLES=100, COUNT_WIDTH=8):
- Reset and idle behaviour:
  - Stimulus: reset_n low with led_i=0xFFFF toggling; then release with enable_i=0 for 500 cycles.
  - Required: all outputs 0, no window_valid_o pulse.
- Static levels:
  - Stimulus: enable_i=1; led_i=0x00F0 held static.
  - Required: first valid pulse 100+SYNC_STAGES+1 cycles (+1 cycle for the registered pulse) after enable_i rises, i.e. 104 cycles with SYNC_STAGES=2, counting from the cycle enable_i is first sampled high.
  - Required: led_state_o=0x0000_5500; rd_sel_i=4 -> rd_count_o=0; windows_done_o=1.
- Blink counting:
  - Stimulus: led_i[0] toggles every 5 cycles (10 rising edges per window).
  - Required: rd_sel_i=0 -> 10 each window; state bits [1:0]=2'b10; windows_done_o increments each window with no gap.
- Saturation:
  - Stimulus: led_i[15] toggles every cycle (50 rises per window); bench rerun with WINDOW_CYCLES=600 so there are 300 rises per window.
  - Required: count=255, state bits [31:30]=2'b11.
- Terminal-cycle edge:
  - Stimulus: a single rising edge on led_i[3] timed to be sampled in the terminal cycle.
  - Required: count=1 in that window; count=0 and state=ON (flag from the still-high level) in the next window.
- Abort:
  - Stimulus: drop enable_i at window cycle 50.
  - Required: no valid pulse; shadows and windows_done_o unchanged.
  - Stimulus: re-raise enable_i.
  - Required: FLUSH then a full 100-cycle window before the next valid pulse.
